// File: rtl/instr_fetch_unit_if.sv
// Bus between the instruction fetch unit and its environment: program loading,
// run control, the decoded-instruction valid/ready handshake and status.
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 10
);
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic [ADDR_W-1:0]  last_addr;
    logic [1:0]         opcode;
    logic [3:0]         reg_a;
    logic [3:0]         reg_b;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               done;

    modport master (
        output load_en, load_addr, load_data, start, last_addr, instr_ready,
        input  opcode, reg_a, reg_b, instr_valid, pc, busy, done
    );

    modport slave (
        input  load_en, load_addr, load_data, start, last_addr, instr_ready,
        output opcode, reg_a, reg_b, instr_valid, pc, busy, done
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch/decode front end of the 4-bit mini processor: program memory, PC and a
// FETCH -> DECODE -> ISSUE sequencer feeding the execute core over valid/ready.
module instr_fetch_unit_chk #(
    parameter int ADDR_W = 4
) (
    input logic              clk,
    input logic              reset,
    input logic              in_issue,
    input logic              in_done,
    input logic              valid,
    input logic              busy,
    input logic              done,
    input logic [ADDR_W-1:0] pc,
    input logic [ADDR_W-1:0] end_addr
);
    // Registered status flags must always agree with the sequencer state.
    a_valid_issue: assert property (@(posedge clk) disable iff (reset) valid == in_issue);
    a_done_state:  assert property (@(posedge clk) disable iff (reset) done == in_done);
    a_busy_done:   assert property (@(posedge clk) disable iff (reset) !(busy && done));
    a_pc_bound:    assert property (@(posedge clk) disable iff (reset) busy |-> (pc <= end_addr));
endmodule

module instr_fetch_unit #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 10
) (
    input logic               clk,
    input logic               reset,
    instr_fetch_unit_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_ISSUE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [1:0] field_op(input logic [INSTR_W-1:0] word);
        return word[9:8];
    endfunction

    function automatic logic [3:0] field_a(input logic [INSTR_W-1:0] word);
        return word[7:4];
    endfunction

    function automatic logic [3:0] field_b(input logic [INSTR_W-1:0] word);
        return word[3:0];
    endfunction

    state_t             state_r;
    state_t             state_s;
    logic [INSTR_W-1:0] mem_r [DEPTH];
    logic [INSTR_W-1:0] ir_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  end_r;
    logic [1:0]         opcode_r;
    logic [3:0]         reg_a_r;
    logic [3:0]         reg_b_r;
    logic               valid_r;
    logic               busy_r;
    logic               done_r;
    logic               idle_like_s;
    logic               load_ok_s;
    logic               start_ok_s;
    logic               handshake_s;
    logic               at_end_s;

    // Next-state logic and the qualified load/start/handshake strobes.
    always_comb begin
        state_s     = state_r;
        idle_like_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
        load_ok_s   = idle_like_s && bus.load_en;
        start_ok_s  = idle_like_s && bus.start;
        handshake_s = (state_r == ST_ISSUE) && bus.instr_ready;
        at_end_s    = (pc_r == end_r);
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH:  state_s = ST_DECODE;
            ST_DECODE: state_s = ST_ISSUE;
            ST_ISSUE: begin
                if (bus.instr_ready) begin
                    if (at_end_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Program memory survives reset; writes only land while the sequencer is parked.
    always_ff @(posedge clk) begin
        if (!reset && load_ok_s) begin
            mem_r[bus.load_addr] <= bus.load_data;
        end
    end

    // PC, instruction register, decoded outputs and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r     <= {ADDR_W{1'b0}};
            end_r    <= {ADDR_W{1'b0}};
            ir_r     <= {INSTR_W{1'b0}};
            opcode_r <= 2'b00;
            reg_a_r  <= 4'h0;
            reg_b_r  <= 4'h0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            // The PC stops on the final address, so a full-depth program never wraps.
            if (start_ok_s) begin
                pc_r  <= {ADDR_W{1'b0}};
                end_r <= bus.last_addr;
            end else if (handshake_s && !at_end_s) begin
                pc_r <= pc_r + ADDR_W'(1);
            end
            if (state_r == ST_FETCH) begin
                ir_r <= mem_r[pc_r];
            end
            if (state_r == ST_DECODE) begin
                opcode_r <= field_op(ir_r);
                reg_a_r  <= field_a(ir_r);
                reg_b_r  <= field_b(ir_r);
                valid_r  <= 1'b1;
            end else if (handshake_s) begin
                valid_r <= 1'b0;
            end
            busy_r <= (state_s == ST_FETCH) || (state_s == ST_DECODE) || (state_s == ST_ISSUE);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign bus.opcode      = opcode_r;
    assign bus.reg_a       = reg_a_r;
    assign bus.reg_b       = reg_b_r;
    assign bus.instr_valid = valid_r;
    assign bus.pc          = pc_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;

    instr_fetch_unit_chk #(.ADDR_W(ADDR_W)) u_chk (
        .clk      (clk),
        .reset    (reset),
        .in_issue (state_r == ST_ISSUE),
        .in_done  (state_r == ST_DONE),
        .valid    (valid_r),
        .busy     (busy_r),
        .done     (done_r),
        .pc       (pc_r),
        .end_addr (end_r)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised scoreboard bench for instr_fetch_unit: a program-level model predicts
// the issued instruction stream, handshake timing, stalls, done status and reset.
module tb_instr_fetch_unit;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 10;
    localparam int DEPTH   = 16;

    typedef struct {
        int                 addr;
        logic [INSTR_W-1:0] word;
        bit                 last;
        int                 rise_at;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tmo_cnt = 0;
    exp_t sbq[$];
    logic [INSTR_W-1:0] model_mem [DEPTH];

    instr_fetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   exp_rise = -1;
    int   done_at = -1;
    int   done_pc = 0;
    int   tmo_seen = 0;
    int   want_rise;
    bit   prev_valid = 1'b0;
    bit   prev_reset = 1'b0;
    bit   hold = 1'b0;
    logic [1:0]        h_op;
    logic [3:0]        h_a;
    logic [3:0]        h_b;
    logic [ADDR_W-1:0] h_pc;
    exp_t mon_e;

    always @(negedge clk) begin
        if (tmo_cnt != tmo_seen) begin
            chk("run_timeout", 32'(tmo_cnt - tmo_seen), 32'd0);
            tmo_seen = tmo_cnt;
        end
        if (prev_reset) begin
            chk("rst_valid", 32'(bus.instr_valid), 32'd0);
            chk("rst_pc", 32'(bus.pc), 32'd0);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_done", 32'(bus.done), 32'd0);
            chk("rst_opcode", 32'(bus.opcode), 32'd0);
            chk("rst_reg_a", 32'(bus.reg_a), 32'd0);
            chk("rst_reg_b", 32'(bus.reg_b), 32'd0);
        end
        if (reset) begin
            hold       = 1'b0;
            prev_valid = 1'b0;
            exp_rise   = -1;
            done_at    = -1;
        end else begin
            if (hold) begin
                chk("stall_valid", 32'(bus.instr_valid), 32'd1);
                chk("stall_opcode", 32'(bus.opcode), 32'(h_op));
                chk("stall_reg_a", 32'(bus.reg_a), 32'(h_a));
                chk("stall_reg_b", 32'(bus.reg_b), 32'(h_b));
                chk("stall_pc", 32'(bus.pc), 32'(h_pc));
            end
            hold = 1'b0;
            if (bus.instr_valid && !prev_valid) begin
                want_rise = exp_rise;
                if (sbq.size() > 0 && sbq[0].rise_at >= 0) want_rise = sbq[0].rise_at;
                chk("valid_rise_cycle", 32'(cyc), 32'(want_rise));
                exp_rise = -1;
            end
            if (done_at == cyc) begin
                chk("done_flag", 32'(bus.done), 32'd1);
                chk("done_busy", 32'(bus.busy), 32'd0);
                chk("done_valid", 32'(bus.instr_valid), 32'd0);
                chk("done_pc", 32'(bus.pc), 32'(done_pc));
                done_at = -1;
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_issue", 32'd1, 32'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("issue_opcode", 32'(bus.opcode), 32'(mon_e.word[9:8]));
                    chk("issue_reg_a", 32'(bus.reg_a), 32'(mon_e.word[7:4]));
                    chk("issue_reg_b", 32'(bus.reg_b), 32'(mon_e.word[3:0]));
                    chk("issue_pc", 32'(bus.pc), 32'(mon_e.addr));
                    if (mon_e.last) begin
                        done_at = cyc + 1;
                        done_pc = mon_e.addr;
                    end else begin
                        exp_rise = cyc + 3;
                    end
                end
            end else if (bus.instr_valid) begin
                hold = 1'b1;
                h_op = bus.opcode;
                h_a  = bus.reg_a;
                h_b  = bus.reg_b;
                h_pc = bus.pc;
            end
            prev_valid = bus.instr_valid;
        end
        prev_reset = reset;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [INSTR_W-1:0] w);
        bus.load_en   = 1'b1;
        bus.load_addr = ADDR_W'(a);
        bus.load_data = w;
        model_mem[a]  = w;
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic push_program(input int last);
        for (int a = 0; a <= last; a++) begin
            exp_t e;
            e.addr    = a;
            e.word    = model_mem[a];
            e.last    = (a == last);
            e.rise_at = (a == 0) ? cyc + 3 : -1;
            sbq.push_back(e);
        end
    endtask

    task automatic run(input int last, input int rdy_pct, input int stall, input bit noise, input bit lws);
        int budget;
        int la;
        bus.start     = 1'b1;
        bus.last_addr = ADDR_W'(last);
        if (lws) begin
            la            = int'($urandom_range(0, last));
            bus.load_en   = 1'b1;
            bus.load_addr = ADDR_W'(la);
            bus.load_data = INSTR_W'($urandom);
            model_mem[la] = bus.load_data;
        end
        push_program(last);
        tick();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        budget = 0;
        while (sbq.size() > 0 && budget < 400) begin
            bus.instr_ready = (budget >= stall) && (int'($urandom_range(0, 99)) < rdy_pct);
            if (noise) begin
                bus.load_en   = ($urandom_range(0, 3) == 0);
                bus.load_addr = ADDR_W'($urandom);
                bus.load_data = INSTR_W'($urandom);
                bus.start     = ($urandom_range(0, 3) == 0);
                bus.last_addr = ADDR_W'($urandom);
            end
            tick();
            budget++;
        end
        bus.start       = 1'b0;
        bus.load_en     = 1'b0;
        bus.instr_ready = 1'b0;
        if (sbq.size() > 0) begin
            tmo_cnt++;
            sbq.delete();
        end
        repeat (2) tick();
    endtask

    task automatic run_with_reset(input int last);
        int n;
        bus.start     = 1'b1;
        bus.last_addr = ADDR_W'(last);
        push_program(last);
        tick();
        bus.start       = 1'b0;
        bus.instr_ready = 1'b0;
        n = 0;
        while (!bus.instr_valid && n < 20) begin
            tick();
            n++;
        end
        if (!bus.instr_valid) tmo_cnt++;
        reset = 1'b1;
        sbq.delete();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int nl;
        reset           = 1'b1;
        bus.load_en     = 1'b0;
        bus.load_addr   = '0;
        bus.load_data   = '0;
        bus.start       = 1'b0;
        bus.last_addr   = '0;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        load_word(0, 10'b00_0011_0101);
        load_word(1, 10'b01_1001_0010);
        load_word(2, 10'b10_1100_1010);
        run(2, 100, 0, 1'b0, 1'b0);
        run(2, 100, 6, 1'b0, 1'b0);
        run(2, 60, 0, 1'b1, 1'b0);
        run(2, 100, 0, 1'b0, 1'b0);
        run(0, 100, 0, 1'b0, 1'b0);
        run(0, 100, 0, 1'b0, 1'b0);
        run_with_reset(2);
        run(2, 100, 0, 1'b0, 1'b0);

        for (int i = 0; i < DEPTH; i++) load_word(i, INSTR_W'($urandom));
        run(15, 100, 0, 1'b0, 1'b0);
        run(15, 50, 0, 1'b1, 1'b1);

        for (int it = 0; it < 20; it++) begin
            nl = int'($urandom_range(0, 4));
            for (int j = 0; j < nl; j++) load_word(int'($urandom_range(0, 15)), INSTR_W'($urandom));
            run(int'($urandom_range(0, 15)), int'($urandom_range(30, 100)), int'($urandom_range(0, 5)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
